energy_detector: RTL and testbench
==================================

# energy_detector

Streaming energy detector that sits directly downstream of the `fir` stage. It pops filtered samples from the FIR's output FIFO and squares each one into signal power in the shared fixed-point format. It keeps a sliding-window average of that power and writes the average to the next FIFO, one word per input sample. A hysteresis comparator on the average drives a registered `detect` level for event flagging.

## Interface
- `DATA_SIZE`, 64: sample and output word width, signed fixed-point.
- `FRAC_BITS`, 10: fractional bits of the fixed-point format; must match the package `QBITS`.
- `WIN_LOG2`, 4: log2 of the averaging window length (window = 16 samples).
- `THRESH_ON`, 2048: average strictly above this sets `detect` (fixed-point, 2.0).
- `THRESH_OFF`, 1024: average strictly below this clears `detect` (fixed-point, 1.0); must be ≤ `THRESH_ON`.

Ports:
- `clock`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_empty`, input, 1: upstream FIFO empty.
- `in_dout`, input, DATA_SIZE: upstream FIFO head word, first-word fall-through, valid whenever `in_empty`=0.
- `in_rd_en`, output, 1: pop upstream FIFO.
- `out_full`, input, 1: downstream FIFO full.
- `out_wr_en`, output, 1: push downstream FIFO.
- `out_din`, output, DATA_SIZE: window-average power.
- `detect`, output, 1: hysteresis detection level.

## Operation
- FSM `READ → MUL → ACC → WRITE → READ`; reset state `READ`.
- **READ:** when `in_empty`=0, assert `in_rd_en` for exactly one cycle, capture `in_dout` into `x_reg`, go to MUL. Otherwise hold and keep `in_rd_en`=0.
- **MUL:**
  - Compute the full 2·DATA_SIZE signed product `x_reg*x_reg`, then arithmetic-shift right by `FRAC_BITS`.
  - Saturate to 2^(DATA_SIZE-1)-1 if the shifted result exceeds it.
  - Register the result as `p_reg`, which is always ≥ 0.
- **ACC:**
  - Read `oldest` from the window slot at `wr_ptr`.
  - Update `sum <= sum + p_reg - oldest`.
  - Write `p_reg` to the slot and advance `wr_ptr` mod 2^WIN_LOG2; it wraps 15→0.
  - `sum` is DATA_SIZE+WIN_LOG2 bits unsigned, so it never overflows.
  - `avg = (sum_next >> WIN_LOG2)`, truncated to DATA_SIZE bits, registered into `avg_reg`.
  - Hysteresis is evaluated on the new avg:
    - If `detect`=0 and avg > `THRESH_ON`, set `detect`.
    - If `detect`=1 and avg < `THRESH_OFF`, clear `detect`.
    - Otherwise hold `detect`.
- **WRITE:** `out_din`=`avg_reg`. When `out_full`=0, assert `out_wr_en` for one cycle and go to READ. Otherwise stall with `out_din` stable. No read occurs in WRITE.
- **Warm-up:** all window slots reset to 0, so the first 2^WIN_LOG2-1 outputs are partial sums divided by the full window. No special-case logic.

## Timing
- Reset (`reset`=0, asynchronous):
  - State goes to READ.
  - `in_rd_en`, `out_wr_en`, `detect` = 0.
  - `out_din`, `sum`, `wr_ptr`, `x_reg`, `p_reg`, `avg_reg` and all window slots = 0.
- Reset mid-operation discards the in-flight sample. Behaviour after release is identical to power-up.
- Latency: the `in_rd_en` cycle is N; `out_wr_en` is earliest at N+3. `detect` updates at the N+2 edge.
- Throughput: at most one sample per 4 cycles. `in_rd_en` and `out_wr_en` are never asserted in the same cycle.
- `out_full` stalls only WRITE; `in_empty` stalls only READ. Each may persist indefinitely without data loss.

## Structure
- Shared package `energy_pkg`:
  - `state_t` enum {READ, MUL, ACC, WRITE}.
  - `QBITS` constant.
  - `dequantize()` function (shift plus saturate), so the rounding rule is defined in one place.
- Sub-module `window_buffer`:
  - 2^WIN_LOG2 × DATA_SIZE circular register file with reset-to-zero.
  - Combinational read of the slot at `wr_ptr`, plus a synchronous write-and-advance strobe.
  - Outputs `oldest`.

## Test plan
- **Constant fill:** 16 samples of 2048 (2.0) → outputs 256, 512, …, 4096 (k·256). `detect` rises on sample 9 (avg 2304), not on sample 8 (avg 2048).
- **Sign independence:** 16 samples of -2048 → outputs identical to the constant-fill run.
- **Hysteresis decay:** after a full window of 2048, feed zeros → avg 4096-256·m. `detect` stays high through m=12 (avg 1024) and clears at m=13 (avg 768).
- **Saturation:** single sample 2^62 → power saturates to 2^63-1, output (2^63-1)>>4. The next sample of 0 gives the same output; no wrap to negative.
- **Backpressure/starvation:**
  - Hold `out_full`=1 for 5 cycles in WRITE → `out_wr_en`=0 and `in_rd_en`=0 throughout, `out_din` stable, one write on release.
  - Hold `in_empty`=1 → no pops and no writes.
- **Reset mid-window:** apply reset after 7 samples of 2048, then replay the constant-fill sequence → outputs and `detect` match the constant-fill run exactly.

Source files
------------

// File: rtl/energy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : energy_pkg
//  Description : Shared definitions for the energy detector: FSM state
//                encoding, fixed-point format constant and the single
//                dequantize (shift + saturate) rule applied to squared
//                samples.
//  Revision    : 1.0 - initial release
// ============================================================================
package energy_pkg;

    // Fractional bits of the shared fixed-point sample format.
    localparam int QBITS = 10;

    // Word width the dequantize rule is written for; the top-level
    // DATA_SIZE must match it.
    localparam int DEQ_WIDTH = 64;

    typedef enum logic [1:0] {
        READ  = 2'd0,
        MUL   = 2'd1,
        ACC   = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Bring a full-width product back to the sample format: arithmetic shift
    // right by the fractional bits, then clamp into the non-negative range of
    // a DEQ_WIDTH-bit signed word. Squares never go negative, so the lower
    // clamp is only a guard.
    function automatic logic [DEQ_WIDTH-1:0] dequantize(
        input logic signed [2*DEQ_WIDTH-1:0] prod,
        input int                            frac
    );
        logic signed [2*DEQ_WIDTH-1:0] shifted;
        logic signed [2*DEQ_WIDTH-1:0] max_val;
        shifted = prod >>> frac;
        max_val = $signed({{(DEQ_WIDTH+1){1'b0}}, {(DEQ_WIDTH-1){1'b1}}});
        if (shifted > max_val) begin
            dequantize = max_val[DEQ_WIDTH-1:0];
        end else if (shifted < 0) begin
            dequantize = '0;
        end else begin
            dequantize = shifted[DEQ_WIDTH-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : window_buffer
//  Description : Circular register file holding the last 2^WIN_LOG2 power
//                values. The slot under the write pointer (the oldest entry)
//                is read combinationally; a push strobe overwrites that slot
//                and advances the pointer.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous active-low reset (clears all slots)
//                push   - write din into the oldest slot and advance
//                din    - value to store
//                oldest - current content of the slot under the pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module window_buffer #(
    parameter int DATA_SIZE = 64,
    parameter int WIN_LOG2  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] oldest
);

    localparam int c_depth = 1 << WIN_LOG2;

    logic [WIN_LOG2-1:0]                 r_wr_ptr;
    logic [c_depth-1:0][DATA_SIZE-1:0]   w_slots;

    // Pointer wraps naturally at 2^WIN_LOG2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
        end else if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    genvar i;
    generate
        for (i = 0; i < c_depth; i++) begin : g_slot
            logic [DATA_SIZE-1:0] r_slot;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_slot <= '0;
                end else if (push && (r_wr_ptr == WIN_LOG2'(i))) begin
                    r_slot <= din;
                end
            end

            assign w_slots[i] = r_slot;
        end
    endgenerate

    assign oldest = w_slots[r_wr_ptr];

endmodule
`default_nettype wire

// File: rtl/energy_detector.sv
`default_nettype none
// ============================================================================
//  Module      : energy_detector
//  Description : Streaming energy detector. Pops one sample from the upstream
//                FWFT FIFO, squares it into fixed-point power, keeps a
//                2^WIN_LOG2 sliding-window average and pushes one average per
//                sample downstream. A hysteresis comparator on the average
//                drives a registered detect level.
//  Ports       : clock     - rising-edge clock
//                reset     - asynchronous active-low reset
//                in_empty  - upstream FIFO empty
//                in_dout   - upstream FIFO head word (valid when !in_empty)
//                in_rd_en  - upstream pop strobe
//                out_full  - downstream FIFO full
//                out_wr_en - downstream push strobe
//                out_din   - window-average power
//                detect    - hysteresis detection level
//  Revision    : 1.0 - initial release
// ============================================================================
module energy_detector
    import energy_pkg::*;
#(
    parameter int                   DATA_SIZE  = 64,
    parameter int                   FRAC_BITS  = 10,
    parameter int                   WIN_LOG2   = 4,
    parameter logic [DATA_SIZE-1:0] THRESH_ON  = DATA_SIZE'(2048),
    parameter logic [DATA_SIZE-1:0] THRESH_OFF = DATA_SIZE'(1024)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_empty,
    input  logic [DATA_SIZE-1:0] in_dout,
    output logic                 in_rd_en,
    input  logic                 out_full,
    output logic                 out_wr_en,
    output logic [DATA_SIZE-1:0] out_din,
    output logic                 detect
);

    // Sum of 2^WIN_LOG2 non-negative DATA_SIZE-bit powers needs WIN_LOG2
    // extra bits, so it can never overflow.
    localparam int c_sum_w = DATA_SIZE + WIN_LOG2;

    state_t                         r_state;
    state_t                         w_state_next;

    logic signed [DATA_SIZE-1:0]    r_x;
    logic [DATA_SIZE-1:0]           r_p;
    logic [c_sum_w-1:0]             r_sum;
    logic [DATA_SIZE-1:0]           r_avg;
    logic                           r_detect;

    logic signed [2*DATA_SIZE-1:0]  w_prod;
    logic [DATA_SIZE-1:0]           w_oldest;
    logic [c_sum_w-1:0]             w_sum_next;
    logic [DATA_SIZE-1:0]           w_avg;
    logic                           w_detect_next;
    logic                           w_acc;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= READ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and FIFO strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_rd_en     = 1'b0;
        out_wr_en    = 1'b0;
        unique case (r_state)
            READ: begin
                // Qualified with reset so no pop is issued while reset is
                // held, even though the state already sits in READ.
                if (!in_empty && reset) begin
                    in_rd_en     = 1'b1;
                    w_state_next = MUL;
                end
            end
            MUL: begin
                w_state_next = ACC;
            end
            ACC: begin
                w_state_next = WRITE;
            end
            WRITE: begin
                if (!out_full) begin
                    out_wr_en    = 1'b1;
                    w_state_next = READ;
                end
            end
            default: begin
                w_state_next = READ;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_acc  = (r_state == ACC);

    // Operands are extended to the full product width before multiplying.
    assign w_prod = r_x * r_x;

    // The oldest entry is always part of r_sum, so the subtraction cannot
    // underflow.
    assign w_sum_next = r_sum + c_sum_w'(r_p) - c_sum_w'(w_oldest);
    assign w_avg      = w_sum_next[c_sum_w-1:WIN_LOG2];

    always_comb begin
        w_detect_next = r_detect;
        if (!r_detect && (w_avg > THRESH_ON)) begin
            w_detect_next = 1'b1;
        end else if (r_detect && (w_avg < THRESH_OFF)) begin
            w_detect_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_x      <= '0;
            r_p      <= '0;
            r_sum    <= '0;
            r_avg    <= '0;
            r_detect <= 1'b0;
        end else begin
            if (in_rd_en) begin
                r_x <= in_dout;
            end
            if (r_state == MUL) begin
                r_p <= dequantize(w_prod, FRAC_BITS);
            end
            if (w_acc) begin
                r_sum    <= w_sum_next;
                r_avg    <= w_avg;
                r_detect <= w_detect_next;
            end
        end
    end

    window_buffer #(
        .DATA_SIZE (DATA_SIZE),
        .WIN_LOG2  (WIN_LOG2)
    ) u_window_buffer (
        .clock  (clock),
        .reset  (reset),
        .push   (w_acc),
        .din    (r_p),
        .oldest (w_oldest)
    );

    assign out_din = r_avg;
    assign detect  = r_detect;

endmodule
`default_nettype wire

// File: tb/tb_energy_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_energy_detector
//  Description : Self-checking bench for energy_detector. Directed scenarios
//                plus randomized samples, compared against a queue-based
//                arithmetic model of the windowed power average.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_energy_detector;

    localparam int DW = 64;

    logic          clock    = 1'b0;
    logic          reset    = 1'b0;
    logic          in_empty = 1'b1;
    logic          out_full = 1'b0;
    logic [DW-1:0] in_dout  = '0;
    logic          in_rd_en;
    logic          out_wr_en;
    logic [DW-1:0] out_din;
    logic          detect;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] m_pow_q[$];
    logic          m_detect   = 1'b0;
    logic [DW-1:0] m_last_avg = '0;

    energy_detector dut (
        .clock     (clock),
        .reset     (reset),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .in_rd_en  (in_rd_en),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .detect    (detect)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Power of one sample: square, divide by 2^10, clamp to 2^63-1.
    function automatic logic [DW-1:0] model_power(input logic [DW-1:0] x);
        logic signed [127:0] xs;
        logic signed [127:0] sq;
        xs = $signed(x);
        sq = xs * xs;
        sq = sq / 1024;
        if (sq > 128'sh7FFF_FFFF_FFFF_FFFF) return 64'h7FFF_FFFF_FFFF_FFFF;
        return sq[DW-1:0];
    endfunction

    // Average over the last 16 powers, missing entries counting as zero.
    task automatic model_step(input logic [DW-1:0] x, output logic [DW-1:0] avg);
        logic [127:0] total;
        m_pow_q.push_back(model_power(x));
        if (m_pow_q.size() > 16) void'(m_pow_q.pop_front());
        total = '0;
        foreach (m_pow_q[k]) total = total + 128'(m_pow_q[k]);
        total = total / 16;
        avg = total[DW-1:0];
        if (!m_detect && avg > 64'd2048)      m_detect = 1'b1;
        else if (m_detect && avg < 64'd1024)  m_detect = 1'b0;
        m_last_avg = avg;
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        out_full = 1'b0;
        in_empty = 1'b0;   // a ready FIFO must not be popped during reset
        #1;
        check("rst_rd_en",  64'(in_rd_en),  64'd0);
        check("rst_wr_en",  64'(out_wr_en), 64'd0);
        check("rst_detect", 64'(detect),    64'd0);
        check("rst_out_din", out_din,       64'd0);
        in_empty = 1'b1;
        m_pow_q.delete();
        m_detect   = 1'b0;
        m_last_avg = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    // One full transaction: offer x, expect pop, expect write 3 cycles later
    // (plus 'stall' cycles of downstream full), check value and detect.
    task automatic send_sample(input logic [DW-1:0] x, input int stall);
        logic [DW-1:0] exp_avg;
        int n;
        model_step(x, exp_avg);
        out_full = (stall > 0);
        in_dout  = x;
        in_empty = 1'b0;
        #1;
        n = 0;
        while (!in_rd_en && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("pop_seen", 64'(in_rd_en), 64'd1);
        if (!in_rd_en) begin
            in_empty = 1'b1;
            out_full = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        in_empty = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("busy_strobes", {62'd0, in_rd_en, out_wr_en}, 64'd0);
        end
        @(negedge clock);
        for (int i = 0; i < stall; i++) begin
            check("stall_strobes", {62'd0, in_rd_en, out_wr_en}, 64'd0);
            check("stall_hold", out_din, exp_avg);
            @(negedge clock);
        end
        out_full = 1'b0;
        #1;
        check("write_strobe", 64'(out_wr_en), 64'd1);
        check("no_pop_in_write", 64'(in_rd_en), 64'd0);
        check("avg", out_din, exp_avg);
        check("detect", 64'(detect), 64'(m_detect));
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [DW-1:0]       x;
        logic signed [DW-1:0] xs;
        int                  v;

        // Reset state
        apply_reset();

        // Constant fill: 16 x 2.0 -> k*256, detect rises at sample 9
        for (int k = 1; k <= 16; k++) begin
            send_sample(64'd2048, 0);
            check("fill_formula", out_din, 64'(k * 256));
        end

        // Hysteresis decay: zeros; detect holds through avg 1024, clears at 768
        for (int m = 1; m <= 16; m++) begin
            send_sample(64'd0, 0);
            check("decay_detect", 64'(detect), (m <= 12) ? 64'd1 : 64'd0);
        end

        // Sign independence (window is all zero and detect low again)
        for (int k = 1; k <= 16; k++) begin
            send_sample(-64'sd2048, 0);
            check("neg_formula", out_din, 64'(k * 256));
        end

        // Reset mid-window: 7 samples, pop an 8th, reset while it is in flight
        apply_reset();
        for (int k = 1; k <= 7; k++) send_sample(64'd2048, 0);
        in_dout  = 64'd2048;
        in_empty = 1'b0;
        #1;
        v = 0;
        while (!in_rd_en && v < 20) begin
            @(negedge clock);
            v++;
        end
        check("mid_pop_seen", 64'(in_rd_en), 64'd1);
        @(posedge clock);
        #1;
        in_empty = 1'b1;
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            send_sample(64'd2048, 0);
            check("replay_formula", out_din, 64'(k * 256));
            check("replay_detect", 64'(detect), (k >= 9) ? 64'd1 : 64'd0);
        end

        // Saturation: 2^62 squared overflows; next zero keeps the same output
        apply_reset();
        send_sample(64'h4000_0000_0000_0000, 0);
        check("sat_value", out_din, 64'h07FF_FFFF_FFFF_FFFF);
        send_sample(64'd0, 0);
        check("sat_hold", out_din, 64'h07FF_FFFF_FFFF_FFFF);

        // Backpressure: 5 cycles of downstream full in WRITE
        send_sample(64'd4096, 5);
        @(negedge clock);
        check("single_write", 64'(out_wr_en), 64'd0);

        // Starvation: empty upstream, nothing moves
        in_empty = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("starve_strobes", {62'd0, in_rd_en, out_wr_en}, 64'd0);
        end
        check("starve_out_din", out_din, m_last_avg);

        // Randomized samples with random stalls and idle gaps
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    v  = int'($urandom_range(0, 8191)) - 4096;
                    xs = v;
                    x  = xs;
                end
                1: begin
                    xs = $signed($urandom);
                    x  = xs;
                end
                2: x = {$urandom, $urandom};
                default: x = '0;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clock);
            send_sample(x, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
